// File: rtl/i2c_pkg.sv
// Shared I2C definitions: engine command opcodes, completion error codes and
// the transaction sequencer's state encoding.
package i2c_pkg;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_ADDR_NACK = 2'b01;
  localparam logic [1:0] ERR_DATA_NACK = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_ADDR_W = 4'd2;
  localparam logic [3:0] ST_REG    = 4'd3;
  localparam logic [3:0] ST_WDATA  = 4'd4;
  localparam logic [3:0] ST_RSTART = 4'd5;
  localparam logic [3:0] ST_ADDR_R = 4'd6;
  localparam logic [3:0] ST_RDATA  = 4'd7;
  localparam logic [3:0] ST_STOP   = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       nack;
  } cmd_t;

  // Every state other than IDLE and DONE drives exactly one engine command.
  function automatic logic is_cmd_state(input logic [3:0] st);
    return (st != ST_IDLE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/i2c_cmd_timer.sv
// Per-command watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module i2c_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] count_q;

  // Saturates at LAST so a caller that ignores expire never sees a wrap.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + TMO_W'(1);
    end
  end

  assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/i2c_xact_sequencer.sv
// Register-level I2C transaction sequencer: turns one register read/write
// request into START/WRITE/READ/STOP engine commands with ACK and timeout checks.
module i2c_xact_sequencer
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RNW,
  input  logic [6:0] REQ_DEV,
  input  logic [7:0] REQ_REG,
  input  logic [7:0] REQ_WDATA,
  output logic       DONE,
  output logic [1:0] ERR,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic [1:0] CMD_OP,
  output logic [7:0] CMD_DATA,
  output logic       CMD_NACK,
  input  logic       RSP_VALID,
  input  logic       RSP_ACK,
  input  logic [7:0] RSP_DATA
);

  // Handshakes: a request transfers on REQ_VALID & REQ_READY; an engine
  // command transfers on CMD_VALID & CMD_READY and is then outstanding until
  // the single RSP_VALID cycle that completes it.

  logic [3:0] state_q, state_d;
  logic       wait_q, wait_d;
  logic [1:0] err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rnw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;

  logic accept;
  logic in_cmd;
  logic rsp_taken;
  logic tmr_clear;
  logic tmr_expire;
  cmd_t cmd;

  assign accept    = REQ_VALID && (state_q == ST_IDLE);
  assign in_cmd    = is_cmd_state(state_q);
  assign rsp_taken = in_cmd && wait_q && RSP_VALID;
  assign tmr_clear = accept || rsp_taken;

  i2c_cmd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (tmr_clear),
    .enable (in_cmd),
    .expire (tmr_expire)
  );

  always_comb begin
    cmd.op   = OP_START;
    cmd.data = 8'h00;
    cmd.nack = 1'b0;
    case (state_q)
      ST_ADDR_W: begin cmd.op = OP_WRITE; cmd.data = {dev_q, 1'b0}; end
      ST_REG:    begin cmd.op = OP_WRITE; cmd.data = reg_q;         end
      ST_WDATA:  begin cmd.op = OP_WRITE; cmd.data = wdata_q;       end
      ST_ADDR_R: begin cmd.op = OP_WRITE; cmd.data = {dev_q, 1'b1}; end
      ST_RDATA:  begin cmd.op = OP_READ;  cmd.nack = 1'b1;          end
      ST_STOP:   cmd.op = OP_STOP;
      default:   cmd.op = OP_START;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          state_d = ST_START;
          wait_d  = 1'b0;
          err_d   = ERR_OK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        wait_d  = 1'b0;
      end
      default: begin
        if (rsp_taken) begin
          // A response beats a same-cycle expiry.
          wait_d = 1'b0;
          case (state_q)
            ST_START:  state_d = ST_ADDR_W;
            ST_ADDR_W: begin
              state_d = RSP_ACK ? ST_REG : ST_STOP;
              if (!RSP_ACK && (err_q == ERR_OK)) err_d = ERR_ADDR_NACK;
            end
            ST_REG: begin
              state_d = !RSP_ACK ? ST_STOP : (rnw_q ? ST_RSTART : ST_WDATA);
              if (!RSP_ACK && (err_q == ERR_OK)) err_d = ERR_DATA_NACK;
            end
            ST_WDATA: begin
              state_d = ST_STOP;
              if (!RSP_ACK && (err_q == ERR_OK)) err_d = ERR_DATA_NACK;
            end
            ST_RSTART: state_d = ST_ADDR_R;
            ST_ADDR_R: begin
              state_d = RSP_ACK ? ST_RDATA : ST_STOP;
              if (!RSP_ACK && (err_q == ERR_OK)) err_d = ERR_ADDR_NACK;
            end
            ST_RDATA: begin
              state_d = ST_STOP;
              rdata_d = RSP_DATA;
            end
            ST_STOP:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
          endcase
        end else if (tmr_expire) begin
          // Abandon the bus without a STOP; an earlier NACK code survives.
          state_d = ST_DONE;
          wait_d  = 1'b0;
          if (err_q == ERR_OK) err_d = ERR_TIMEOUT;
        end else if (!wait_q && CMD_READY) begin
          wait_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b0;
      err_q   <= ERR_OK;
      rdata_q <= 8'h00;
      rnw_q   <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        rnw_q   <= REQ_RNW;
        dev_q   <= REQ_DEV;
        reg_q   <= REQ_REG;
        wdata_q <= REQ_WDATA;
      end
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_DONE);
  assign ERR       = err_q;
  assign RDATA     = rdata_q;
  assign CMD_VALID = in_cmd && !wait_q;
  assign CMD_OP    = cmd.op;
  assign CMD_DATA  = cmd.data;
  assign CMD_NACK  = cmd.nack;

endmodule

// File: tb/tb_i2c_xact_sequencer.sv
// Bench for i2c_xact_sequencer: scripted engine responder, directed vector
// table with hand-derived results, and randomized transactions against a model.
module tb_i2c_xact_sequencer;

  localparam int TMO = 16;

  localparam logic [1:0] B_START = 2'b00;
  localparam logic [1:0] B_WRITE = 2'b01;
  localparam logic [1:0] B_READ  = 2'b10;
  localparam logic [1:0] B_STOP  = 2'b11;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID, REQ_READY, REQ_RNW;
  logic [6:0] REQ_DEV;
  logic [7:0] REQ_REG, REQ_WDATA;
  logic       DONE, BUSY;
  logic [1:0] ERR;
  logic [7:0] RDATA;
  logic       CMD_VALID, CMD_READY, CMD_NACK;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_DATA;
  logic       RSP_VALID, RSP_ACK;
  logic [7:0] RSP_DATA;

  always #5 CLK = ~CLK;

  i2c_xact_sequencer #(.TIMEOUT_CYCLES(TMO), .TMO_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RNW(REQ_RNW),
    .REQ_DEV(REQ_DEV), .REQ_REG(REQ_REG), .REQ_WDATA(REQ_WDATA),
    .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_DATA(CMD_DATA), .CMD_NACK(CMD_NACK),
    .RSP_VALID(RSP_VALID), .RSP_ACK(RSP_ACK), .RSP_DATA(RSP_DATA)
  );

  // Engine script (how the responder behaves) plus the expected outcome.
  typedef struct {
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] regaddr;
    logic [7:0] wdata;
    logic [7:0] rsp_rdata;
    int         rd;        // CMD_READY low cycles before accepting
    int         rs;        // wait cycle (1-based) carrying RSP_VALID
    int         nack_k;    // issued-command index answered with ACK=0
    int         hang_k;    // issued-command index never answered
    int         rst_k;     // issued-command index whose WAIT gets RST
    bit         spurious;  // random RSP_VALID while nothing outstanding
    int         exp_ncmd;
    logic [1:0] exp_err;
    logic [7:0] exp_rdata;
    int         exp_done;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [10:0] exp_q[$];   // {op, nack, data}
  logic [7:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ_VALID = 1'b0; REQ_RNW = 1'b0; REQ_DEV = 7'h00; REQ_REG = 8'h00; REQ_WDATA = 8'h00;
    CMD_READY = 1'b0; RSP_VALID = 1'b0; RSP_ACK = 1'b0; RSP_DATA = 8'h00;
  endtask

  // DATA matters only for WRITE, NACK only for READ.
  function automatic logic [10:0] norm(input logic [10:0] w);
    logic [10:0] r;
    r = w;
    if (r[10:9] != B_WRITE) r[7:0] = 8'h00;
    if (r[10:9] != B_READ)  r[8] = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] wd, input logic [7:0] rsd, input int rd, input int rs,
                              input int nk, input int hk, input int rk, input bit sp,
                              input int en, input logic [1:0] ee, input logic [7:0] er, input int ed);
    vec_t v;
    v.rnw = rnw; v.dev = dev; v.regaddr = ra; v.wdata = wd; v.rsp_rdata = rsd;
    v.rd = rd; v.rs = rs; v.nack_k = nk; v.hang_k = hk; v.rst_k = rk; v.spurious = sp;
    v.exp_ncmd = en; v.exp_err = ee; v.exp_rdata = er; v.exp_done = ed;
    return v;
  endfunction

  // Reference model: walks the bus-level byte list of a register access,
  // charging rd+1+rs cycles per command, and pushes the expected stream.
  task automatic model_xact(input vec_t v, input logic [7:0] prev_rd, output int ncmd,
                            output logic [1:0] err, output logic [7:0] rd_o, output int done);
    logic [10:0] seq[$];
    int pos, k, cyc;
    logic [10:0] c;
    seq.push_back({B_START, 1'b0, 8'h00});
    seq.push_back({B_WRITE, 1'b0, v.dev, 1'b0});
    seq.push_back({B_WRITE, 1'b0, v.regaddr});
    if (v.rnw) begin
      seq.push_back({B_START, 1'b0, 8'h00});
      seq.push_back({B_WRITE, 1'b0, v.dev, 1'b1});
      seq.push_back({B_READ, 1'b1, 8'h00});
    end else begin
      seq.push_back({B_WRITE, 1'b0, v.wdata});
    end
    seq.push_back({B_STOP, 1'b0, 8'h00});
    err = 2'b00; rd_o = prev_rd; cyc = 1; k = 0; pos = 0; done = -1; ncmd = 0;
    while (pos < seq.size()) begin
      c = seq[pos];
      exp_q.push_back(c);
      k++;
      if (k - 1 == v.rst_k) begin
        ncmd = k; err = 2'b00; rd_o = 8'h00; done = -1;
        return;
      end
      if ((k - 1 == v.hang_k) || (v.rd + v.rs >= TMO)) begin
        if (err == 2'b00) err = 2'b11;
        ncmd = k; done = cyc + TMO;
        return;
      end
      cyc += v.rd + 1 + v.rs;
      if ((c[10:9] == B_WRITE) && (k - 1 == v.nack_k)) begin
        if (err == 2'b00) err = ((pos == 1) || (v.rnw && pos == 4)) ? 2'b01 : 2'b10;
        pos = seq.size() - 1;
      end else begin
        if (c[10:9] == B_READ) rd_o = v.rsp_rdata;
        pos++;
      end
    end
    ncmd = k; done = cyc;
  endtask

  task automatic run_xact(input vec_t v, input int exp_ncmd, input logic [1:0] exp_err,
                          input logic [7:0] exp_rdata, input int exp_done);
    int cyc, k, wait_cnt, rdy_cnt, seen;
    bit outstanding, holding, finished, rst_path;
    logic [10:0] hold_word, word, exp_w;
    logic [1:0] last_op;
    REQ_VALID = 1'b1; REQ_RNW = v.rnw; REQ_DEV = v.dev; REQ_REG = v.regaddr; REQ_WDATA = v.wdata;
    check("req_ready_idle", REQ_READY, 1);
    step();
    REQ_VALID = 1'b0; REQ_RNW = 1'($urandom); REQ_DEV = 7'($urandom);
    REQ_REG = 8'($urandom); REQ_WDATA = 8'($urandom);
    cyc = 1; k = 0; wait_cnt = 0; rdy_cnt = 0; outstanding = 0; holding = 0;
    finished = 0; rst_path = 0; hold_word = '0; last_op = B_START;
    while (!finished && cyc < 300) begin
      if (cyc == 1) begin
        check("busy_after_accept", BUSY, 1);
        check("err_clear_on_accept", ERR, 0);
        check("first_cmd_valid", CMD_VALID, 1);
      end
      CMD_READY = 1'b0; RSP_VALID = 1'b0; RSP_ACK = 1'($urandom); RSP_DATA = 8'($urandom);
      if (DONE) begin
        check("done_cycle", cyc, exp_done);
        check("done_err", ERR, exp_err);
        check("done_rdata", RDATA, exp_rdata);
        check("done_busy", BUSY, 1);
        finished = 1;
        RSP_ACK = 1'b0; RSP_DATA = 8'h00;
      end else if (outstanding) begin
        wait_cnt++;
        check("cmd_valid_in_wait", CMD_VALID, 0);
        if ((v.rst_k == k - 1) && (wait_cnt == 1)) begin
          RST = 1'b1;
          step();
          RST = 1'b0;
          check("rst_cmd_valid", CMD_VALID, 0);
          check("rst_busy", BUSY, 0);
          check("rst_req_ready", REQ_READY, 1);
          check("rst_done", DONE, 0);
          check("rst_err", ERR, exp_err);
          check("rst_rdata", RDATA, exp_rdata);
          finished = 1; rst_path = 1;
        end else if ((k - 1 != v.hang_k) && (wait_cnt == v.rs)) begin
          RSP_VALID = 1'b1;
          RSP_ACK = (k - 1 != v.nack_k);
          if (last_op == B_READ) RSP_DATA = v.rsp_rdata;
          outstanding = 0;
        end
      end else begin
        if (v.spurious) RSP_VALID = 1'($urandom);
        if (CMD_VALID) begin
          word = {CMD_OP, CMD_NACK, CMD_DATA};
          if (!holding) begin
            holding = 1; hold_word = word; rdy_cnt = 0;
          end else begin
            check("cmd_stable", word, hold_word);
          end
          if (rdy_cnt == v.rd) begin
            CMD_READY = 1'b1;
            if (exp_q.size() == 0) begin
              check("extra_cmd", norm(word), 11'h7ff);
            end else begin
              exp_w = exp_q.pop_front();
              check("cmd_word", norm(word), norm(exp_w));
            end
            k++; outstanding = 1; wait_cnt = 0; holding = 0; last_op = CMD_OP;
          end else begin
            rdy_cnt++;
          end
        end
      end
      if (!rst_path) begin
        step();
        cyc++;
      end
    end
    idle_inputs();
    if (!finished) begin
      checks++; errors++;
      $display("FAIL done_wait: no DONE within %0d cycles, required cycle %0d", cyc, exp_done);
    end else if (rst_path) begin
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        seen += int'(DONE) + int'(CMD_VALID);
        step();
      end
      check("quiet_after_rst", seen, 0);
    end else begin
      check("done_one_cycle", DONE, 0);
      check("ready_after_done", REQ_READY, 1);
      check("busy_after_done", BUSY, 0);
      step(); step();
      check("err_held", ERR, exp_err);
      check("rdata_held", RDATA, exp_rdata);
    end
    check("num_cmds", k, exp_ncmd);
    if (!rst_path) check("cmds_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[12];
    vec_t v;
    int m_n, m_d;
    logic [1:0] m_e;
    logic [7:0] m_r;

    //          rnw  dev    reg    wdata  rsp    rd rs nk hk rk sp  ncmd err    rdata  done
    tbl[0]  = mk(0, 7'h50, 8'h10, 8'h3C, 8'h00, 0, 1, -1, -1, -1, 0, 5, 2'b00, 8'h00, 11);
    tbl[1]  = mk(1, 7'h50, 8'h22, 8'h00, 8'hA5, 0, 1, -1, -1, -1, 0, 7, 2'b00, 8'hA5, 15);
    tbl[2]  = mk(0, 7'h33, 8'h10, 8'h99, 8'h00, 0, 1,  1, -1, -1, 0, 3, 2'b01, 8'hA5, 7);
    tbl[3]  = mk(1, 7'h50, 8'h22, 8'h00, 8'h11, 0, 1,  2, -1, -1, 0, 4, 2'b10, 8'hA5, 9);
    tbl[4]  = mk(0, 7'h50, 8'h10, 8'h3C, 8'h00, 0, 1, -1,  0, -1, 0, 1, 2'b11, 8'hA5, 17);
    tbl[5]  = mk(0, 7'h21, 8'h40, 8'h0F, 8'h00, 0, 15, -1, -1, -1, 0, 5, 2'b00, 8'hA5, 81);
    tbl[6]  = mk(0, 7'h21, 8'h40, 8'h0F, 8'h00, 0, 16, -1, -1, -1, 0, 1, 2'b11, 8'hA5, 17);
    tbl[7]  = mk(0, 7'h11, 8'h02, 8'hFE, 8'h00, 5, 1, -1, -1, -1, 1, 5, 2'b00, 8'hA5, 36);
    tbl[8]  = mk(0, 7'h2A, 8'h05, 8'h77, 8'h00, 5, 2, -1, -1,  3, 0, 4, 2'b00, 8'h00, -1);
    tbl[9]  = mk(0, 7'h2A, 8'h05, 8'h77, 8'h00, 0, 1,  3,  4, -1, 0, 5, 2'b10, 8'h00, 25);
    tbl[10] = mk(1, 7'h7F, 8'hC3, 8'h00, 8'h5A, 2, 3, -1, -1, -1, 1, 7, 2'b00, 8'h5A, 43);
    tbl[11] = mk(1, 7'h0C, 8'h81, 8'h00, 8'hEE, 0, 1,  4, -1, -1, 1, 6, 2'b01, 8'h5A, 13);

    idle_inputs();
    RST = 1'b1;
    step(); step(); step();
    check("reset_cmd_valid", CMD_VALID, 0);
    check("reset_done", DONE, 0);
    check("reset_err", ERR, 0);
    check("reset_rdata", RDATA, 0);
    check("reset_busy", BUSY, 0);
    check("reset_req_ready", REQ_READY, 1);
    RST = 1'b0;
    step();
    model_rdata = 8'h00;

    for (int i = 0; i < 12; i++) begin
      model_xact(tbl[i], model_rdata, m_n, m_e, m_r, m_d);
      run_xact(tbl[i], tbl[i].exp_ncmd, tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_done);
      model_rdata = tbl[i].exp_rdata;
    end

    for (int i = 0; i < 40; i++) begin
      v = mk(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3), 1, -1, -1, -1, 1'($urandom), 0, 2'b00, 8'h00, 0);
      v.rs = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 16) : $urandom_range(1, 4);
      v.nack_k = $urandom_range(0, 11);
      v.hang_k = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      model_xact(v, model_rdata, m_n, m_e, m_r, m_d);
      run_xact(v, m_n, m_e, m_r, m_d);
      model_rdata = m_r;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_xact_sequencer.md
Name: i2c_xact_sequencer

Overview:
Register-level transaction sequencer that sits between a host-side requester and the byte-level I2C controller engine.
- Converts one request (single-byte register write, or single-byte register read) into an ordered stream of engine commands: START, WRITE, READ, STOP.
- Checks the ACK status returned for every byte.
- Reports completion, read data and an error code.
- Guards every engine command with a timeout.

Parameters:
TIMEOUT_CYCLES, 65535, max CLK cycles allowed per engine command, counted from first CMD_VALID to RSP_VALID.
TMO_W, 16, width of the timeout counter; requires TIMEOUT_CYCLES < 2**TMO_W.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  sequencer can accept request
REQ_RNW  in  1  1=register read, 0=register write
REQ_DEV  in  7  7-bit target address
REQ_REG  in  8  register address
REQ_WDATA  in  8  write data
DONE  out  1  one-cycle completion pulse
ERR  out  2  00 OK, 01 ADDR_NACK, 10 DATA_NACK, 11 TIMEOUT
RDATA  out  8  read result
BUSY  out  1  transaction in progress
CMD_VALID  out  1  engine command valid
CMD_READY  in  1  engine accepts command
CMD_OP  out  2  00 START, 01 WRITE, 10 READ, 11 STOP
CMD_DATA  out  8  byte for WRITE
CMD_NACK  out  1  for READ: 1 = controller sends NACK
RSP_VALID  in  1  engine finished current command
RSP_ACK  in  1  target ACKed the WRITE byte (ignored for START/STOP/READ)
RSP_DATA  in  8  byte received for READ

Behaviour:
- Reset (RST=1 at a CLK edge) forces:
  - state=IDLE, CMD_VALID=0, DONE=0, ERR=00, RDATA=0x00, BUSY=0.
  - REQ_READY=1 from the first cycle after reset.
  - Reset mid-transaction abandons it with no DONE and no STOP issued; the engine is reset by the same RST.
- REQ_READY = (state==IDLE).
  - Handshake REQ_VALID&REQ_READY latches RNW/DEV/REG/WDATA.
  - BUSY=1 from the next cycle until the DONE cycle (inclusive).
- Write sequence: START, WRITE {DEV,0}, WRITE REG, WRITE WDATA, STOP.
- Read sequence: START, WRITE {DEV,0}, WRITE REG, START (repeated), WRITE {DEV,1}, READ with CMD_NACK=1, STOP.
- States: IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP, DONE.
  - Each command state has an ISSUE phase and a WAIT phase.
- ISSUE phase:
  - CMD_VALID=1 with stable OP/DATA/NACK until CMD_READY.
  - Handshake cycle moves to WAIT; CMD_VALID=0 in WAIT.
- WAIT phase:
  - RSP_VALID advances to the next command state in the same cycle.
  - At most one command is outstanding.
- Per-byte checks:
  - ADDR_W/ADDR_R with RSP_ACK=0: ERR=01, go to STOP.
  - REG/WDATA with RSP_ACK=0: ERR=10, go to STOP.
  - RDATA: RSP_DATA captured into RDATA on RSP_VALID.
- STOP completion: STOP response leads to DONE, which pulses DONE=1 for one cycle, then returns to IDLE.
  - DONE-to-next-request-accept latency is 1 cycle.
- Timing:
  - Write: IDLE accept to first CMD_VALID is 1 cycle.
  - Engine with zero-wait READY and 1-cycle RSP: write DONE 11 cycles after accept.
- Timeout:
  - The counter clears on entry to each ISSUE phase and increments every cycle in ISSUE or WAIT.
  - At count == TIMEOUT_CYCLES-1 without RSP_VALID: ERR=11, go directly to DONE, no STOP issued.
  - RSP_VALID on the same cycle as expiry wins; no timeout is raised.
- Error precedence: a NACK already latched is never overwritten. A timeout during the error STOP keeps the NACK code.
- ERR and RDATA are valid in the DONE cycle and held until the next accepted request.
  - Acceptance clears ERR to 00; RDATA is unchanged on writes.
- A RSP_VALID arriving in IDLE, DONE or an ISSUE phase is ignored.

Decomposition:
- Shared package i2c_pkg holds:
  - CMD_OP codes (OP_START/OP_WRITE/OP_READ/OP_STOP).
  - ERR codes (ERR_OK/ERR_ADDR_NACK/ERR_DATA_NACK/ERR_TIMEOUT).
  - Sequencer state encoding.
- The engine uses the same OP codes.
- One sub-module: i2c_cmd_timer (clear, enable, expire output, parameter TIMEOUT_CYCLES), reusable by the engine for clock-stretch limits.

Test Plan:
- Write DEV=0x50, REG=0x10, WDATA=0x3C, engine all-ACK, 1-cycle RSP -> CMD stream START, WRITE 0xA0, WRITE 0x10, WRITE 0x3C, STOP; DONE at accept+11; ERR=00.
- Read DEV=0x50, REG=0x22, engine returns 0xA5 -> stream START, 0xA0, 0x22, START, WRITE 0xA1, READ(CMD_NACK=1), STOP; RDATA=0xA5, ERR=00.
- Write to absent DEV=0x33 (RSP_ACK=0 on addr byte) -> WRITE 0x66 then STOP, no REG byte; ERR=01.
- Read with RSP_ACK=0 on the REG byte -> STOP follows; ERR=10; RDATA retains its previous value.
- TIMEOUT_CYCLES=16, engine never asserts RSP_VALID after START -> DONE 16 cycles after START issue; ERR=11; no STOP. Separately, RSP_VALID exactly at the expiry cycle -> no timeout.
- CMD_READY held low 5 cycles on each command -> CMD_VALID/OP/DATA stable throughout, correct stream. Then assert RST during WDATA WAIT -> next cycle CMD_VALID=0, BUSY=0, REQ_READY=1, no DONE.
